// File: rtl/feedback_loop_rr_sched_if.sv
// Request/result bundle for feedback_loop_rr_sched: per-channel request lanes in,
// one tagged result out. master = channel sources + consumer side, slave = scheduler.
interface feedback_loop_rr_sched_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned W      = 8,
    parameter int unsigned CH_W   = 2
);
    logic [NUM_CH-1:0]   req_valid;
    logic [NUM_CH-1:0]   req_clear;
    logic [NUM_CH*W-1:0] req_data;
    logic [NUM_CH-1:0]   req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [CH_W-1:0]     out_ch;
    logic [W-1:0]        out_data;

    modport master (
        output req_valid, req_clear, req_data, out_ready,
        input  req_ready, out_valid, out_ch, out_data
    );

    modport slave (
        input  req_valid, req_clear, req_data, out_ready,
        output req_ready, out_valid, out_ch, out_data
    );
endinterface

// File: rtl/feedback_loop_rr_sched.sv
// Round-robin scheduler time-sharing one signed accumulator among NUM_CH channels.
// Define FEEDBACK_LOOP_SAT_EN for saturating adds; the default build wraps.
module feedback_loop_rr_sched #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned W      = 8,
    parameter int unsigned CH_W   = 2
) (
    input logic                     system1000,
    input logic                     system1000_rstn,
    feedback_loop_rr_sched_if.slave bus
);
    typedef enum logic {StEmpty, StFull} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic signed [W-1:0] r_acc [NUM_CH];
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     r_out_ch;
    logic signed [W-1:0] r_out_data;

    logic                w_can_issue;
    logic                w_accept;
    logic [CH_W-1:0]     w_idx;
    logic [CH_W-1:0]     w_gnt;
    logic [NUM_CH-1:0]   w_req_ready;
    logic signed [W-1:0] w_operand;
    logic signed [W-1:0] w_acc_sel;
    logic signed [W-1:0] w_add;
    logic signed [W-1:0] w_sum;
    logic                w_clear;

    // Gating with reset keeps grants low while reset is held.
    assign w_can_issue = system1000_rstn & ((r_state == StEmpty) | bus.out_ready);

    always_comb begin
        w_accept = 1'b0;
        w_gnt    = '0;
        w_idx    = '0;
        if (w_can_issue) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                w_idx = CH_W'((32'(r_rr_ptr) + i) % NUM_CH);
                if (!w_accept && bus.req_valid[w_idx]) begin
                    w_accept = 1'b1;
                    w_gnt    = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[w_gnt] = 1'b1;
        end
    end

    assign w_operand = bus.req_data[32'(w_gnt) * W +: W];
    assign w_acc_sel = r_acc[w_gnt];
    assign w_clear   = bus.req_clear[w_gnt];

`ifdef FEEDBACK_LOOP_SAT_EN
    logic signed [W-1:0] w_raw;

    // Overflow: operands share a sign that the wrapped result does not.
    always_comb begin
        w_raw = w_acc_sel + w_operand;
        w_add = w_raw;
        if ((w_acc_sel[W-1] == w_operand[W-1]) && (w_raw[W-1] != w_acc_sel[W-1])) begin
            w_add = w_acc_sel[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign w_add = w_acc_sel + w_operand;
`endif

    assign w_sum = w_clear ? w_operand : w_add;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StEmpty: if (w_accept) w_state_next = StFull;
            StFull:  if (!w_accept && bus.out_ready) w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            r_state    <= StEmpty;
            r_rr_ptr   <= '0;
            r_out_ch   <= '0;
            r_out_data <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_acc[w_gnt] <= w_sum;
                r_out_data   <= w_sum;
                r_out_ch     <= w_gnt;
                r_rr_ptr     <= CH_W'((32'(w_gnt) + 1) % NUM_CH);
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.out_valid = (r_state == StFull);
    assign bus.out_ch    = r_out_ch;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_feedback_loop_rr_sched.sv
// Bench for feedback_loop_rr_sched: directed scenarios then random traffic, all checked
// against a per-channel running-sum model; honours FEEDBACK_LOOP_SAT_EN.
module tb_feedback_loop_rr_sched;
    localparam int NCH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    feedback_loop_rr_sched_if #(.NUM_CH(4), .W(8), .CH_W(2)) bus ();

    feedback_loop_rr_sched #(.NUM_CH(4), .W(8), .CH_W(2)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .bus             (bus)
    );

    int checks   = 0;
    int failures = 0;

    int m_acc [NCH];
    int m_ptr;
    bit m_full;
    int m_ch;
    int m_data;

    function automatic int fix_sum(input int v);
        logic [7:0] t;
`ifdef FEEDBACK_LOOP_SAT_EN
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
`else
        t = v[7:0];
        return int'($signed(t));
`endif
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) m_acc[k] = 0;
        m_ptr  = 0;
        m_full = 1'b0;
        m_ch   = 0;
        m_data = 0;
    endtask

    // One clock: check grant mid-cycle, advance model at the edge, check outputs after it.
    task automatic tick(input string tag);
        int g;
        int d;
        int s;
        logic [3:0] exp_rdy;
        @(negedge clk);
        g = -1;
        if (rstn && (!m_full || bus.out_ready)) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (g < 0 && bus.req_valid[c]) g = c;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        check({tag, "/ready"}, {28'b0, bus.req_ready}, {28'b0, exp_rdy});
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else if (g >= 0) begin
            d = int'($signed(bus.req_data[g*8 +: 8]));
            s = bus.req_clear[g] ? d : fix_sum(m_acc[g] + d);
            m_acc[g] = s;
            m_data   = s;
            m_ch     = g;
            m_full   = 1'b1;
            m_ptr    = (g + 1) % NCH;
        end else if (m_full && bus.out_ready) begin
            m_full = 1'b0;
        end
        #1;
        check({tag, "/valid"}, {31'b0, bus.out_valid}, {31'b0, m_full});
        check({tag, "/ch"}, {30'b0, bus.out_ch}, m_ch);
        check({tag, "/data"}, $signed(bus.out_data), m_data);
    endtask

    task automatic set_ch(input int ch, input int d);
        bus.req_data[ch*8 +: 8] = 8'(d);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.req_valid = 4'h0;
        bus.req_clear = 4'h0;
        tick("rst");
        rstn = 1'b1;
    endtask

    initial begin
        model_reset();
        bus.req_valid = 4'hF;
        bus.req_clear = 4'h0;
        bus.req_data  = 32'h0101_0101;
        bus.out_ready = 1'b1;

        // Reset held with all channels requesting.
        tick("rst_hold0");
        tick("rst_hold1");
        check("rst_valid_const", {31'b0, bus.out_valid}, 0);
        check("rst_data_const", $signed(bus.out_data), 0);
        rstn = 1'b1;

        // Fairness: 0,1,2,3,0,1,2,3 with sums 1,1,1,1,2,2,2,2.
        for (int k = 0; k < 8; k++) begin
            tick("fair");
            check("fair_ch_const", {30'b0, bus.out_ch}, k % 4);
            check("fair_data_const", $signed(bus.out_data), k / 4 + 1);
        end

        // Backpressure holds the result and blocks grants.
        do_reset();
        bus.req_valid = 4'b0100;
        set_ch(2, 5);
        bus.out_ready = 1'b1;
        tick("bp_first");
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        tick("bp_hold0");
        tick("bp_hold1");
        check("bp_data_const", $signed(bus.out_data), 5);
        bus.out_ready = 1'b1;
        tick("bp_release");
        check("bp_next_ch_const", {30'b0, bus.out_ch}, 3);

        // Clear restarts a channel's sum.
        do_reset();
        bus.req_valid = 4'b0010;
        set_ch(1, 10);
        tick("clr_a");
        check("clr_a_const", $signed(bus.out_data), 10);
        set_ch(1, 20);
        tick("clr_b");
        check("clr_b_const", $signed(bus.out_data), 30);
        bus.req_clear = 4'b0010;
        set_ch(1, 7);
        tick("clr_c");
        check("clr_c_const", $signed(bus.out_data), 7);
        bus.req_clear = 4'b0000;
        set_ch(1, 3);
        tick("clr_d");
        check("clr_d_const", $signed(bus.out_data), 10);

        // Overflow in both directions.
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_clear = 4'b0001;
        set_ch(0, 120);
        tick("ovf_load_pos");
        bus.req_clear = 4'b0000;
        set_ch(0, 10);
        tick("ovf_pos");
`ifdef FEEDBACK_LOOP_SAT_EN
        check("ovf_pos_const", $signed(bus.out_data), 127);
`else
        check("ovf_pos_const", $signed(bus.out_data), -126);
`endif
        bus.req_clear = 4'b0001;
        set_ch(0, -100);
        tick("ovf_load_neg");
        bus.req_clear = 4'b0000;
        set_ch(0, -50);
        tick("ovf_neg");
`ifdef FEEDBACK_LOOP_SAT_EN
        check("ovf_neg_const", $signed(bus.out_data), -128);
`else
        check("ovf_neg_const", $signed(bus.out_data), 106);
`endif

        // Reset mid-run drops the pending result and all sums.
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_clear = 4'b1000;
        set_ch(3, 40);
        bus.out_ready = 1'b1;
        tick("mid_load");
        bus.req_valid = 4'b0000;
        bus.req_clear = 4'b0000;
        bus.out_ready = 1'b0;
        tick("mid_full");
        rstn = 1'b0;
        tick("mid_rst");
        check("mid_rst_valid_const", {31'b0, bus.out_valid}, 0);
        rstn = 1'b1;
        bus.req_valid = 4'b1000;
        set_ch(3, 1);
        bus.out_ready = 1'b1;
        tick("mid_after");
        check("mid_after_const", $signed(bus.out_data), 1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rstn          = ($urandom_range(0, 40) != 0);
            bus.req_valid = 4'($urandom);
            bus.req_clear = 4'($urandom & $urandom);
            bus.req_data  = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
